// File: rtl/pipe_stage_skid_if.sv
// Handshake/payload bundle between a pipeline stage and its neighbours.
// The slave view belongs to the stage; the master view drives its inputs and observes its outputs.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register as a two-entry skid buffer: 1-cycle latency, full throughput.
// in_ready comes only from state flops; a stall absorbs one extra entry before in_ready drops.
module pipe_stage_skid #(
  parameter int DATA_W              = 32,
  parameter int CTRL_W              = 8,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  pipe_stage_skid_if.slave bus
);
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_ready  = (r_state != S_FULL);
  assign w_out_valid = (r_state != S_EMPTY);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_data_nxt = r_skid_data;
    // Flush wins over everything; an entry offered in the same cycle is dropped.
    if (bus.flush) begin
      w_state_nxt     = S_EMPTY;
      w_main_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        w_main_data_nxt = '0;
        w_skid_data_nxt = '0;
      end
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_main_ctrl_nxt = bus.in_ctrl;
            w_main_data_nxt = bus.in_data;
            w_state_nxt     = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_ctrl_nxt = bus.in_ctrl;
            w_main_data_nxt = bus.in_data;
          end else if (w_in_fire) begin
            w_skid_ctrl_nxt = bus.in_ctrl;
            w_skid_data_nxt = bus.in_data;
            w_state_nxt     = S_FULL;
          end else if (w_out_fire) begin
            // Draining leaves a bubble: control goes inert, data is left as-is.
            w_main_ctrl_nxt = '0;
            w_state_nxt     = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
            w_skid_ctrl_nxt = '0;
            w_state_nxt     = S_ONE;
          end
        end
        default: begin
          w_state_nxt     = S_EMPTY;
          w_main_ctrl_nxt = '0;
          w_skid_ctrl_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_EMPTY;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      r_main_data <= '0;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign bus.out_data  = r_main_data;
  assign bus.occupancy = r_state;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a 32/8 instance clearing data on flush and a 64/1 instance holding it.
module tb_pipe_stage_skid;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(8)) ifa ();
  pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(1)) ifb ();

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA_ON_FLUSH(1'b1)) u_dut_a (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (ifa.slave)
  );

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(1), .CLEAR_DATA_ON_FLUSH(1'b0)) u_dut_b (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (ifb.slave)
  );

  logic [39:0] qa[$];
  logic [64:0] qb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitors: compare every completed transfer against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.out_valid && ifa.out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_out actual=0x%0h expected=none", {ifa.out_ctrl, ifa.out_data});
        end else begin
          check("a_out", {ifa.out_ctrl, ifa.out_data}, qa.pop_front());
        end
      end
      if (!ifa.out_valid) check("a_bubble_ctrl", ifa.out_ctrl, 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifb.out_valid && ifb.out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_out actual=0x%0h expected=none", {ifb.out_ctrl, ifb.out_data});
        end else begin
          check("b_out", {ifb.out_ctrl, ifb.out_data}, qb.pop_front());
        end
      end
      if (!ifb.out_valid) check("b_bubble_ctrl", ifb.out_ctrl, 0);
    end
  end

  // Input trackers run after the output monitors so a same-cycle flush keeps the completed transfer.
  always @(negedge clk) begin
    #1;
    if (!rst_n || ifa.flush) qa.delete();
    else if (ifa.in_valid && ifa.in_ready) qa.push_back({ifa.in_ctrl, ifa.in_data});
  end

  always @(negedge clk) begin
    #1;
    if (!rst_n || ifb.flush) qb.delete();
    else if (ifb.in_valid && ifb.in_ready) qb.push_back({ifb.in_ctrl, ifb.in_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.in_valid = 0; ifa.in_ctrl = '0; ifa.in_data = '0; ifa.flush = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_ctrl = '0; ifb.in_data = '0; ifb.flush = 0; ifb.out_ready = 0;

    #12;
    check("rst_in_ready", ifa.in_ready, 1);
    check("rst_out_valid", ifa.out_valid, 0);
    check("rst_occ", ifa.occupancy, 0);
    check("rst_out_data", ifa.out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Streaming 1..8 at full rate
    ifa.out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      ifa.in_valid = 1;
      ifa.in_ctrl  = 8'(8'h10 + i);
      ifa.in_data  = 32'(i);
      check("stream_in_ready", ifa.in_ready, 1);
      step();
      check("stream_out_valid", ifa.out_valid, 1);
      check("stream_out_data", ifa.out_data, 32'(i));
    end
    ifa.in_valid = 0;
    step();
    check("stream_drain_valid", ifa.out_valid, 0);
    check("stream_drain_occ", ifa.occupancy, 0);

    // Drain bubble: control zeroed, data kept
    ifa.out_ready = 0;
    ifa.in_valid = 1; ifa.in_ctrl = 8'h81; ifa.in_data = 32'h5A5A;
    step();
    check("bubble_ctrl_held", ifa.out_ctrl, 8'h81);
    ifa.in_valid = 0; ifa.out_ready = 1;
    step();
    check("bubble_valid", ifa.out_valid, 0);
    check("bubble_ctrl", ifa.out_ctrl, 8'h00);
    check("bubble_data_kept", ifa.out_data, 32'h5A5A);

    // Stall: A, B fill the stage, C waits upstream
    ifa.out_ready = 0;
    ifa.in_valid = 1; ifa.in_ctrl = 8'h0A; ifa.in_data = 32'hA;
    step();
    check("stall_occ1", ifa.occupancy, 1);
    check("stall_rdy1", ifa.in_ready, 1);
    ifa.in_ctrl = 8'h0B; ifa.in_data = 32'hB;
    step();
    check("stall_occ2", ifa.occupancy, 2);
    check("stall_rdy0", ifa.in_ready, 0);
    ifa.in_ctrl = 8'h0C; ifa.in_data = 32'hC;
    step();
    check("stall_hold_data", ifa.out_data, 32'hA);
    check("stall_hold_occ", ifa.occupancy, 2);
    ifa.out_ready = 1;
    step();
    check("release_occ", ifa.occupancy, 1);
    check("release_data_b", ifa.out_data, 32'hB);
    check("release_rdy", ifa.in_ready, 1);
    step();
    check("release_data_c", ifa.out_data, 32'hC);
    ifa.in_valid = 0;
    step();
    check("release_empty", ifa.occupancy, 0);

    // Flush while FULL, with an incoming entry offered
    ifa.out_ready = 0;
    ifa.in_valid = 1; ifa.in_ctrl = 8'hFF; ifa.in_data = 32'h11;
    step();
    ifa.in_data = 32'h22;
    step();
    check("flush_full_occ", ifa.occupancy, 2);
    ifa.flush = 1; ifa.in_data = 32'h33;
    step();
    ifa.flush = 0; ifa.in_valid = 0;
    check("flush_valid", ifa.out_valid, 0);
    check("flush_ctrl", ifa.out_ctrl, 8'h00);
    check("flush_data", ifa.out_data, 0);
    check("flush_occ", ifa.occupancy, 0);
    check("flush_rdy", ifa.in_ready, 1);
    step();
    check("flush_dropped", ifa.out_valid, 0);

    // Flush in ONE: accepted-looking input dropped, presented output still completes
    ifa.in_valid = 1; ifa.in_ctrl = 8'h0F; ifa.in_data = 32'h44;
    step();
    check("flush1_occ", ifa.occupancy, 1);
    ifa.flush = 1; ifa.in_data = 32'h55; ifa.out_ready = 1;
    step();
    ifa.flush = 0; ifa.in_valid = 0;
    check("flush1_occ0", ifa.occupancy, 0);
    check("flush1_data", ifa.out_data, 0);
    step();
    check("flush1_dropped", ifa.out_valid, 0);

    // Asynchronous reset while FULL
    ifa.out_ready = 0;
    ifa.in_valid = 1; ifa.in_ctrl = 8'h77; ifa.in_data = 32'h66;
    step();
    ifa.in_data = 32'h67;
    step();
    ifa.in_valid = 0;
    check("prerst_occ", ifa.occupancy, 2);
    #3;
    rst_n = 0;
    #1;
    check("arst_out_valid", ifa.out_valid, 0);
    check("arst_out_ctrl", ifa.out_ctrl, 0);
    check("arst_occ", ifa.occupancy, 0);
    check("arst_in_ready", ifa.in_ready, 1);
    check("arst_out_data", ifa.out_data, 0);
    step();
    step();
    rst_n = 1;
    step();

    // Wide instance, data held on flush
    ifb.out_ready = 0;
    ifb.in_valid = 1; ifb.in_ctrl = 1'b1; ifb.in_data = 64'hDEADBEEF_CAFEF00D;
    step();
    check("b_occ1", ifb.occupancy, 1);
    ifb.in_data = 64'h01234567_89ABCDEF;
    step();
    check("b_occ2", ifb.occupancy, 2);
    check("b_stall_data", ifb.out_data, 64'hDEADBEEF_CAFEF00D);
    ifb.in_valid = 0; ifb.flush = 1;
    step();
    ifb.flush = 0;
    check("b_flush_valid", ifb.out_valid, 0);
    check("b_flush_ctrl", ifb.out_ctrl, 0);
    check("b_flush_data_held", ifb.out_data, 64'hDEADBEEF_CAFEF00D);
    ifb.in_valid = 1; ifb.in_data = 64'hDEADBEEF_CAFEF00D;
    step();
    ifb.in_data = 64'hFFFFFFFF_00000001;
    step();
    check("b_stall2_occ", ifb.occupancy, 2);
    ifb.in_valid = 0; ifb.out_ready = 1;
    step();
    check("b_release_data", ifb.out_data, 64'hFFFFFFFF_00000001);
    step();
    step();

    check("a_sb_empty", qa.size(), 0);
    check("b_sb_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
